bcd2bin: RTL and testbench



---
 rtl/bcd2bin.sv | 115 +++++++++++
 tb/tb_bcd2bin.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bcd2bin.sv
// Digit-serial signed BCD (sign + 4 digits) to 11-bit two's-complement converter.
// Optional range/digit checking is built when BCD2BIN_ERRCHK_EN is defined.
module bcd2bin (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [16:0] i_bcd,
  input  logic        i_bcd_vld,
  output logic        o_bcd_rdy,
  output logic [10:0] o_bin,
  output logic        o_bin_vld,
  output logic        o_bin_err
);

  typedef enum logic [1:0] {StIdle, StConv, StOut} state_e;

  state_e      r_state;
  logic [16:0] r_bcd;
  logic [14:0] r_acc;
  logic [1:0]  r_idx;
  logic [10:0] r_bin;
  logic        r_bin_vld;

  logic [3:0]  w_digit;
  logic [14:0] w_acc_nxt;
  logic [10:0] w_mag;
  logic [10:0] w_res;

  always_comb begin
    w_digit = 4'd0;
    unique case (r_idx)
      2'd3: w_digit = r_bcd[15:12];
      2'd2: w_digit = r_bcd[11:8];
      2'd1: w_digit = r_bcd[7:4];
      2'd0: w_digit = r_bcd[3:0];
      default: w_digit = 4'd0;
    endcase
  end

  // acc*10 via shifts; 15 bits holds the all-0xF worst case without wrapping
  assign w_acc_nxt = (r_acc << 3) + (r_acc << 1) + {11'd0, w_digit};
  assign w_mag     = {1'b0, r_acc[9:0]};
  assign w_res     = r_bcd[16] ? (11'd0 - w_mag) : w_mag;

`ifdef BCD2BIN_ERRCHK_EN
  logic r_dig_err;
  logic r_bin_err;
  logic w_dig_bad;

  assign w_dig_bad = (i_bcd[15:12] > 4'd9) || (i_bcd[11:8] > 4'd9) ||
                     (i_bcd[7:4] > 4'd9) || (i_bcd[3:0] > 4'd9);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state   <= StIdle;
      r_bcd     <= '0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_bin     <= '0;
      r_bin_vld <= 1'b0;
`ifdef BCD2BIN_ERRCHK_EN
      r_dig_err <= 1'b0;
      r_bin_err <= 1'b0;
`endif
    end else begin
      r_bin_vld <= 1'b0;
`ifdef BCD2BIN_ERRCHK_EN
      r_bin_err <= 1'b0;
`endif
      case (r_state)
        StIdle: begin
          if (i_bcd_vld) begin
            r_bcd   <= i_bcd;
            r_acc   <= '0;
            r_idx   <= 2'd3;
            r_state <= StConv;
`ifdef BCD2BIN_ERRCHK_EN
            r_dig_err <= w_dig_bad;
`endif
          end
        end
        StConv: begin
          r_acc <= w_acc_nxt;
          r_idx <= r_idx - 2'd1;
          if (r_idx == 2'd0) r_state <= StOut;
        end
        StOut: begin
          r_bin_vld <= 1'b1;
          r_state   <= StIdle;
`ifdef BCD2BIN_ERRCHK_EN
          if (r_dig_err || (r_acc > 15'd1023)) begin
            r_bin     <= '0;
            r_bin_err <= 1'b1;
          end else begin
            r_bin <= w_res;
          end
`else
          r_bin <= w_res;
`endif
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_bcd_rdy = (r_state == StIdle);
  assign o_bin     = r_bin;
  assign o_bin_vld = r_bin_vld;
`ifdef BCD2BIN_ERRCHK_EN
  assign o_bin_err = r_bin_err;
`else
  assign o_bin_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench for bcd2bin: directed corner cases plus random words checked
// against an arithmetic reference model (honours BCD2BIN_ERRCHK_EN).
module tb_bcd2bin;

  logic        clk;
  logic        rstn;
  logic [16:0] bcd;
  logic        bcd_vld;
  logic        bcd_rdy;
  logic [10:0] bin;
  logic        bin_vld;
  logic        bin_err;

  int n_chk  = 0;
  int n_fail = 0;

  bcd2bin u_dut (
    .i_clk     (clk),
    .i_rstn    (rstn),
    .i_bcd     (bcd),
    .i_bcd_vld (bcd_vld),
    .o_bcd_rdy (bcd_rdy),
    .o_bin     (bin),
    .o_bin_vld (bin_vld),
    .o_bin_err (bin_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {err, bin}: decimal value of the digits, then range/sign rules.
  function automatic logic [11:0] model(input logic [16:0] w);
    int d3, d2, d1, d0, mag, m;
    logic err;
    logic [10:0] res;
    d3  = int'(w[15:12]);
    d2  = int'(w[11:8]);
    d1  = int'(w[7:4]);
    d0  = int'(w[3:0]);
    mag = d3 * 1000 + d2 * 100 + d1 * 10 + d0;
`ifdef BCD2BIN_ERRCHK_EN
    err = (d3 > 9) || (d2 > 9) || (d1 > 9) || (d0 > 9) || (mag > 1023);
    m   = mag;
`else
    err = 1'b0;
    m   = mag % 1024;
`endif
    if (err)        res = 11'd0;
    else if (w[16]) res = 11'(-m);
    else            res = 11'(m);
    return {err, res};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word from idle and check the full 5-edge timing and result.
  task automatic send_and_check(input logic [16:0] w, input string tag);
    logic [11:0] exp;
    exp = model(w);
    check({tag, " rdy_before"}, 16'(bcd_rdy), 16'd1);
    bcd     = w;
    bcd_vld = 1'b1;
    tick();
    bcd_vld = 1'b0;
    check({tag, " rdy_after_xfer"}, 16'(bcd_rdy), 16'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k < 5) begin
        check({tag, " vld_early"}, 16'(bin_vld), 16'd0);
        check({tag, " rdy_busy"}, 16'(bcd_rdy), 16'd0);
      end else begin
        check({tag, " vld"}, 16'(bin_vld), 16'd1);
        check({tag, " bin"}, 16'(bin), 16'(exp[10:0]));
        check({tag, " err"}, 16'(bin_err), 16'(exp[11]));
        check({tag, " rdy_done"}, 16'(bcd_rdy), 16'd1);
      end
    end
    tick();
    check({tag, " vld_pulse"}, 16'(bin_vld), 16'd0);
    check({tag, " err_pulse"}, 16'(bin_err), 16'd0);
    check({tag, " bin_hold"}, 16'(bin), 16'(exp[10:0]));
  endtask

  initial begin
    logic [16:0] w;
    rstn    = 1'b0;
    bcd     = '0;
    bcd_vld = 1'b0;
    tick();
    tick();
    check("reset rdy", 16'(bcd_rdy), 16'd1);
    check("reset bin", 16'(bin), 16'd0);
    check("reset vld", 16'(bin_vld), 16'd0);
    check("reset err", 16'(bin_err), 16'd0);
    rstn = 1'b1;
    tick();

    send_and_check({1'b0, 16'h0937}, "pos937");
    check("pos937 const", 16'(bin), 16'h3A9);
    send_and_check({1'b1, 16'h1023}, "neg1023");
    check("neg1023 const", 16'(bin), 16'h401);
    send_and_check({1'b1, 16'h0000}, "negzero");
    send_and_check({1'b0, 16'h1024}, "over1024");
    send_and_check({1'b0, 16'h00A5}, "baddigit");

    // vld held high: +0001 taken, busy-time words dropped, +0002 taken at N+6
    bcd     = {1'b0, 16'h0001};
    bcd_vld = 1'b1;
    tick();
    check("stream rdy_low", 16'(bcd_rdy), 16'd0);
    bcd = {1'b0, 16'h0003};
    tick();
    tick();
    tick();
    bcd = {1'b0, 16'h0002};
    tick();
    check("stream first_early", 16'(bin_vld), 16'd0);
    tick();
    check("stream first_vld", 16'(bin_vld), 16'd1);
    check("stream first_bin", 16'(bin), 16'd1);
    tick();
    check("stream second_taken", 16'(bcd_rdy), 16'd0);
    check("stream vld_low", 16'(bin_vld), 16'd0);
    bcd_vld = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("stream second_early", 16'(bin_vld), 16'd0);
    tick();
    check("stream second_vld", 16'(bin_vld), 16'd1);
    check("stream second_bin", 16'(bin), 16'd2);
    tick();

    // Reset at edge N+2 discards the conversion
    bcd     = {1'b0, 16'h0500};
    bcd_vld = 1'b1;
    tick();
    bcd_vld = 1'b0;
    tick();
    rstn = 1'b0;
    tick();
    check("rst_mid rdy", 16'(bcd_rdy), 16'd1);
    check("rst_mid bin", 16'(bin), 16'd0);
    check("rst_mid vld", 16'(bin_vld), 16'd0);
    check("rst_mid err", 16'(bin_err), 16'd0);
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rst_mid no_vld", 16'(bin_vld), 16'd0);
    end
    send_and_check({1'b0, 16'h0042}, "after_rst");

    for (int i = 0; i < 24; i++) begin
      w[16] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) begin
        w[15:12] = 4'($urandom_range(0, 1));
        w[11:8]  = 4'($urandom_range(0, 9));
        w[7:4]   = 4'($urandom_range(0, 9));
        w[3:0]   = 4'($urandom_range(0, 9));
      end else begin
        w[15:0] = 16'($urandom);
      end
      send_and_check(w, $sformatf("rand%0d_%05h", i, w));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
